popcount_scheduler: RTL and testbench

POPCOUNT_SCHEDULER -- requirements
Module: popcount_scheduler

---
 rtl/popcount_scheduler.sv | 129 ++++++++++++
 tb/tb_popcount_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_scheduler.sv
// Round-robin scheduler that accepts one requester word at a time and counts its
// set bits CHUNK bits per cycle, presenting the result with a valid/ready handshake.
module popcount_scheduler #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int REQ_N = 4
) (
  input  logic                           clk_i,
  input  logic                           arst_i,
  input  logic [REQ_N*WIDTH-1:0]         req_data_i,
  input  logic [REQ_N-1:0]               req_valid_i,
  output logic [REQ_N-1:0]               req_ready_o,
  output logic [$clog2(WIDTH):0]         data_o,
  output logic [((REQ_N > 1) ? $clog2(REQ_N) : 1)-1:0] id_o,
  output logic                           data_val_o,
  input  logic                           data_ready_i,
  output logic                           busy_o
);

  localparam int K   = WIDTH / CHUNK;
  localparam int AW  = $clog2(WIDTH) + 1;
  localparam int IDW = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam int BW  = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [IDW-1:0]   ptr_reg;
  logic [IDW-1:0]   id_reg;
  logic [IDW-1:0]   out_id_reg;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic [WIDTH-1:0] shift_reg;
  logic [AW-1:0]    acc_reg;
  logic [AW-1:0]    out_data_reg;
  logic [AW-1:0]    chunk_cnt;
  logic [BW-1:0]    beat_reg;
  logic             accept;
  logic             last_beat;

  // Search from ptr upward; iterating downward lets the nearest valid win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = REQ_N - 1; i >= 0; i--) begin
      if (req_valid_i[(int'(ptr_reg) + i) % REQ_N]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(ptr_reg) + i) % REQ_N);
      end
    end
  end

  always_comb begin
    chunk_cnt = '0;
    for (int b = 0; b < CHUNK; b++) begin
      chunk_cnt = chunk_cnt + AW'(shift_reg[b]);
    end
  end

  assign accept    = (state_reg == IDLE) && grant_found;
  assign last_beat = (beat_reg == BW'(K - 1));

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)       state_next = COUNT;
      COUNT:   if (last_beat)    state_next = DONE;
      DONE:    if (data_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if ((state_reg == IDLE) && grant_found && !arst_i) begin
      req_ready_o[grant_idx] = 1'b1;
    end
    busy_o     = (state_reg != IDLE);
    data_val_o = (state_reg == DONE);
  end

  // Result registers load only when counting finishes, so they stay put after the handshake.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ptr_reg      <= '0;
      id_reg       <= '0;
      shift_reg    <= '0;
      acc_reg      <= '0;
      beat_reg     <= '0;
      out_data_reg <= '0;
      out_id_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            shift_reg <= req_data_i[grant_idx*WIDTH +: WIDTH];
            id_reg    <= grant_idx;
            acc_reg   <= '0;
            beat_reg  <= '0;
            ptr_reg   <= (grant_idx == IDW'(REQ_N - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
        COUNT: begin
          acc_reg   <= acc_reg + chunk_cnt;
          shift_reg <= shift_reg >> CHUNK;
          beat_reg  <= beat_reg + 1'b1;
          if (last_beat) begin
            out_data_reg <= acc_reg + chunk_cnt;
            out_id_reg   <= id_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_o = out_data_reg;
  assign id_o   = out_id_reg;

endmodule

// File: tb/tb_popcount_scheduler.sv
// Randomized bench for popcount_scheduler: a cycle-level model predicts grants and
// results; a separate monitor checks presented results against the scoreboard.
module tb_popcount_scheduler;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int REQ_N = 4;
  localparam int K     = WIDTH / CHUNK;

  logic                   clk_i = 1'b0;
  logic                   arst_i = 1'b1;
  logic [REQ_N*WIDTH-1:0] req_data_i = '0;
  logic [REQ_N-1:0]       req_valid_i = '0;
  logic [REQ_N-1:0]       req_ready_o;
  logic [4:0]             data_o;
  logic [1:0]             id_o;
  logic                   data_val_o;
  logic                   data_ready_i = 1'b1;
  logic                   busy_o;

  popcount_scheduler #(.WIDTH(WIDTH), .CHUNK(CHUNK), .REQ_N(REQ_N)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .req_data_i(req_data_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o), .data_o(data_o), .id_o(id_o), .data_val_o(data_val_o),
    .data_ready_i(data_ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int id; int data; int cyc;} exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  int m_phase = 0;   // 0 idle, 1 counting, 2 result pending
  int m_ptr = 0;
  int m_beats = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc_cnt);
    end
  endtask

  function automatic int rr_pick(input logic [REQ_N-1:0] v, input int p);
    for (int i = 0; i < REQ_N; i++) begin
      if (v[(p + i) % REQ_N]) return (p + i) % REQ_N;
    end
    return -1;
  endfunction

  // Reference model: advances on each clock edge from the inputs seen at that edge.
  always @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      m_phase <= 0;
      m_ptr   <= 0;
      m_beats <= 0;
      sb.delete();
    end else begin
      cyc_cnt <= cyc_cnt + 1;
      case (m_phase)
        0: begin
          int g;
          g = rr_pick(req_valid_i, m_ptr);
          if (g >= 0) begin
            exp_t e;
            e.id   = g;
            e.data = $countones(req_data_i[g*WIDTH +: WIDTH]);
            e.cyc  = cyc_cnt;
            sb.push_back(e);
            $display("[TB] cycle %0d accept req %0d word %04h expect %0d",
                     cyc_cnt, g, req_data_i[g*WIDTH +: WIDTH], e.data);
            m_ptr   <= (g + 1) % REQ_N;
            m_beats <= K;
            m_phase <= 1;
          end
        end
        1: begin
          m_beats <= m_beats - 1;
          if (m_beats == 1) m_phase <= 2;
        end
        default: if (data_ready_i) m_phase <= 0;
      endcase
    end
  end

  // Per-cycle control checks against the model.
  always @(negedge clk_i) begin
    logic [REQ_N-1:0] exp_rdy;
    int g;
    exp_rdy = '0;
    g = rr_pick(req_valid_i, m_ptr);
    if (m_phase == 0 && g >= 0 && !arst_i) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    check("busy", 64'(busy_o), 64'(m_phase != 0));
    check("data_val", 64'(data_val_o), 64'(m_phase == 2));
  end

  // Monitor: compares each presented result and its stability while held.
  logic       prev_val = 1'b0;
  logic [4:0] held_data = '0;
  logic [1:0] held_id = '0;
  always @(negedge clk_i) begin
    if (arst_i) begin
      prev_val = 1'b0;
    end else begin
      if (data_val_o && !prev_val) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 64'(data_val_o), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("[TB] cycle %0d result id %0d data %0d (expect id %0d data %0d)",
                   cyc_cnt, id_o, data_o, e.id, e.data);
          check("result_data", 64'(data_o), 64'(e.data));
          check("result_id", 64'(id_o), 64'(e.id));
          check("result_latency", 64'(cyc_cnt - e.cyc), 64'(K + 1));
        end
        held_data = data_o;
        held_id   = id_o;
      end else if (data_val_o || prev_val) begin
        check("held_data", 64'(data_o), 64'(held_data));
        check("held_id", 64'(id_o), 64'(held_id));
      end
      prev_val = data_val_o;
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic set_word(input int r, input logic [15:0] w);
    req_data_i[r*WIDTH +: WIDTH] = w;
  endtask

  task automatic do_reset();
    arst_i = 1'b1;
    cyc(2);
    arst_i = 1'b0;
    cyc(1);
  endtask

  initial begin
    #3;
    check("rst_data", 64'(data_o), 64'(0));
    check("rst_id", 64'(id_o), 64'(0));
    check("rst_val", 64'(data_val_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    cyc(2);
    arst_i = 1'b0;
    cyc(1);

    // Single request, all ones.
    set_word(2, 16'hFFFF);
    req_valid_i = 4'b0100;
    cyc(1);
    req_valid_i = '0;
    cyc(8);

    // All four from reset, in-order grants.
    do_reset();
    set_word(0, 16'h0001); set_word(1, 16'h0003);
    set_word(2, 16'h0007); set_word(3, 16'h000F);
    req_valid_i = 4'b1111;
    cyc(19);
    req_valid_i = '0;
    cyc(8);

    // Backpressure for several cycles in DONE, then zero and checkerboard words.
    set_word(1, 16'hA5A5);
    req_valid_i = 4'b0010;
    data_ready_i = 1'b0;
    cyc(1);
    req_valid_i = '0;
    cyc(K + 4);
    data_ready_i = 1'b1;
    cyc(2);
    set_word(0, 16'h0000);
    req_valid_i = 4'b0001;
    cyc(1);
    req_valid_i = '0;
    cyc(8);

    // Reset pulse on the second count cycle discards the request.
    do_reset();
    set_word(0, 16'hFFFF);
    req_valid_i = 4'b0001;
    cyc(1);
    req_valid_i = '0;
    cyc(1);
    arst_i = 1'b1;
    #1;
    check("midrst_data", 64'(data_o), 64'(0));
    check("midrst_val", 64'(data_val_o), 64'(0));
    check("midrst_busy", 64'(busy_o), 64'(0));
    check("midrst_ready", 64'(req_ready_o), 64'(0));
    cyc(2);
    arst_i = 1'b0;
    cyc(1);
    set_word(1, 16'h00FF);
    req_valid_i = 4'b0010;
    cyc(1);
    req_valid_i = '0;
    cyc(8);

    // Two requesters continuously valid must alternate.
    set_word(0, 16'h1234); set_word(3, 16'hF00F);
    req_valid_i = 4'b1001;
    cyc(30);
    req_valid_i = '0;
    cyc(8);

    // Random traffic with random backpressure; data changes every cycle.
    for (int i = 0; i < 400; i++) begin
      req_valid_i  = 4'($urandom_range(0, 15));
      req_data_i   = {$urandom, $urandom};
      data_ready_i = ($urandom_range(0, 3) != 0);
      cyc(1);
    end

    req_valid_i  = '0;
    data_ready_i = 1'b1;
    for (int i = 0; i < 30 && (sb.size() != 0 || m_phase != 0); i++) cyc(1);
    check("drain_pending", 64'(sb.size()), 64'(0));
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
